mux2_reg: RTL and testbench



---
 rtl/mux2_reg_pkg.sv | 10 +
 rtl/sat_counter.sv | 29 ++
 rtl/mux2_reg.sv | 79 +++++++
 tb/tb_mux2_reg.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux2_reg_pkg.sv
// Shared constants for the registered 2:1 selector.
// Select encodings and default widths used by mux2_reg and its bench.
package mux2_reg_pkg;

    localparam int   DEF_WIDTH = 2;
    localparam int   DEF_CNT_W = 16;
    localparam logic SEL_A     = 1'b0;
    localparam logic SEL_B     = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: steps by one on i_inc, sticks at all-ones.
// Cleared asynchronously by an active-high rst.
module sat_counter
    import mux2_reg_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_full;

    assign w_full = (r_cnt == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inc && !w_full) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mux2_reg.sv
// Registered 2:1 selector with a one-cycle capture strobe.
// Define MUX_SWITCH_CNT_EN to add sel_q and the sw_cnt select-change counter.
module mux2_reg
    import mux2_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic             y_vld
`ifdef MUX_SWITCH_CNT_EN
    ,
    output logic             sel_q,
    output logic [CNT_W-1:0] sw_cnt
`endif
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("mux2_reg: WIDTH must be in 1..64");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("mux2_reg: CNT_W must be at least 1");
    end

    logic [WIDTH-1:0] r_y;
    logic             r_vld;
    logic [WIDTH-1:0] w_sel_data;

    assign w_sel_data = (s == SEL_A) ? a : b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y   <= '0;
            r_vld <= 1'b0;
        end else begin
            r_vld <= en;
            if (en) begin
                r_y <= w_sel_data;
            end
        end
    end

    assign y     = r_y;
    assign y_vld = r_vld;

`ifdef MUX_SWITCH_CNT_EN
    logic r_sel_q;
    logic w_switch;

    // Reset value SEL_A means the first capture of s=1 counts as a change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_q <= SEL_A;
        end else if (en) begin
            r_sel_q <= s;
        end
    end

    assign w_switch = en && (s != r_sel_q);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sw_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_switch),
        .o_cnt (sw_cnt)
    );

    assign sel_q = r_sel_q;
`endif

endmodule

// File: tb/tb_mux2_reg.sv
// Self-checking bench for mux2_reg: WIDTH=2 and WIDTH=8 instances,
// plus a CNT_W=2 instance when MUX_SWITCH_CNT_EN is defined.
module tb_mux2_reg;

    logic clk;
    logic rst;

    logic [1:0] a2, b2, y2;
    logic       s2, en2, v2;
    logic [7:0] a8, b8, y8;
    logic       s8, en8, v8;

`ifdef MUX_SWITCH_CNT_EN
    logic        sq2;
    logic [15:0] cnt2;
    logic        sq8;
    logic [15:0] cnt8;
    logic [1:0]  as, bs, ys, cnts;
    logic        ss, ens, vs, sqs;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    mux2_reg #(.WIDTH(2)) u_dut2 (
        .clk    (clk),
        .rst    (rst),
        .a      (a2),
        .b      (b2),
        .s      (s2),
        .en     (en2),
        .y      (y2),
        .y_vld  (v2)
`ifdef MUX_SWITCH_CNT_EN
        ,
        .sel_q  (sq2),
        .sw_cnt (cnt2)
`endif
    );

    mux2_reg #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst    (rst),
        .a      (a8),
        .b      (b8),
        .s      (s8),
        .en     (en8),
        .y      (y8),
        .y_vld  (v8)
`ifdef MUX_SWITCH_CNT_EN
        ,
        .sel_q  (sq8),
        .sw_cnt (cnt8)
`endif
    );

`ifdef MUX_SWITCH_CNT_EN
    mux2_reg #(.WIDTH(2), .CNT_W(2)) u_dut_sat (
        .clk    (clk),
        .rst    (rst),
        .a      (as),
        .b      (bs),
        .s      (ss),
        .en     (ens),
        .y      (ys),
        .y_vld  (vs),
        .sel_q  (sqs),
        .sw_cnt (cnts)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en2 = 1'b0;
        en8 = 1'b0;
`ifdef MUX_SWITCH_CNT_EN
        ens = 1'b0;
`endif
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (y2 !== 2'b00 || v2 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold y=%b vld=%b want 00/0", y2, v2);
        end
        n_cmp++;
        if (y8 !== 8'h00 || v8 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold8 y=%h vld=%b want 00/0", y8, v8);
        end
        rst = 1'b0;
        a2 = 2'b11; b2 = 2'b00; s2 = 1'b0; en2 = 1'b1;
        tick();
        n_cmp++;
        if (y2 !== 2'b11 || v2 !== 1'b1) begin
            n_bad++;
            $display("FAIL first_cap y=%b vld=%b want 11/1", y2, v2);
        end
        // Assert reset between edges and look before the next edge.
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (y2 !== 2'b00 || v2 !== 1'b0) begin
            n_bad++;
            $display("FAIL async_rst y=%b vld=%b want 00/0", y2, v2);
        end
        en2 = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_select_a();
        a2 = 2'b11; b2 = 2'b01; s2 = 1'b0; en2 = 1'b1;
        tick();
        n_cmp++;
        if (y2 !== 2'b11 || v2 !== 1'b1) begin
            n_bad++;
            $display("FAIL sel_a y=%b vld=%b want 11/1", y2, v2);
        end
    endtask

    task automatic test_select_b();
        a2 = 2'b11; b2 = 2'b01; s2 = 1'b1; en2 = 1'b1;
        tick();
        n_cmp++;
        if (y2 !== 2'b01 || v2 !== 1'b1) begin
            n_bad++;
            $display("FAIL sel_b y=%b vld=%b want 01/1", y2, v2);
        end
        s2 = 1'b0;
        tick();
        n_cmp++;
        if (y2 !== 2'b11 || v2 !== 1'b1) begin
            n_bad++;
            $display("FAIL sel_toggle y=%b vld=%b want 11/1", y2, v2);
        end
    endtask

    task automatic test_hold();
        a2 = 2'b11; b2 = 2'b01; s2 = 1'b1; en2 = 1'b1;
        tick();
        n_cmp++;
        if (y2 !== 2'b01) begin
            n_bad++;
            $display("FAIL hold_cap y=%b want 01", y2);
        end
        en2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a2 = 2'($urandom);
            b2 = 2'($urandom);
            s2 = 1'($urandom);
            tick();
            n_cmp++;
            if (y2 !== 2'b01 || v2 !== 1'b0) begin
                n_bad++;
                $display("FAIL hold[%0d] y=%b vld=%b want 01/0", i, y2, v2);
            end
        end
    endtask

    task automatic test_equal_inputs();
        en2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a2 = 2'(i);
            b2 = 2'(i);
            s2 = 1'($urandom);
            tick();
            n_cmp++;
            if (y2 !== 2'(i)) begin
                n_bad++;
                $display("FAIL equal_ab[%0d] y=%b want %b", i, y2, 2'(i));
            end
        end
        en2 = 1'b0;
    endtask

    task automatic test_width_sweep();
        logic [7:0] want;
        a8 = 8'hA5; b8 = 8'h5A; en8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s8 = 1'(i % 2);
            want = (i % 2 == 1) ? 8'h5A : 8'hA5;
            tick();
            n_cmp++;
            if (y8 !== want || v8 !== 1'b1) begin
                n_bad++;
                $display("FAIL sweep8[%0d] y=%h vld=%b want %h/1",
                         i, y8, v8, want);
            end
        end
        en8 = 1'b0;
    endtask

`ifdef MUX_SWITCH_CNT_EN
    task automatic test_switch_cnt();
        int seq [5] = '{0, 1, 1, 0, 1};
        do_reset();
        n_cmp++;
        if (cnt2 !== 16'd0 || sq2 !== 1'b0) begin
            n_bad++;
            $display("FAIL cnt_rst cnt=%0d sel_q=%b want 0/0", cnt2, sq2);
        end
        en2 = 1'b1;
        foreach (seq[i]) begin
            s2 = 1'(seq[i]);
            tick();
        end
        en2 = 1'b0;
        n_cmp++;
        if (cnt2 !== 16'd3 || sq2 !== 1'b1) begin
            n_bad++;
            $display("FAIL cnt_seq cnt=%0d sel_q=%b want 3/1", cnt2, sq2);
        end
        as = 2'b10; bs = 2'b01; ens = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            ss = 1'(k % 2);
            tick();
            n_cmp++;
            if (cnts !== 2'((k > 3) ? 3 : k)) begin
                n_bad++;
                $display("FAIL cnt_sat[%0d] cnt=%0d want %0d",
                         k, cnts, (k > 3) ? 3 : k);
            end
        end
        ens = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [1:0]  last2;
        logic [7:0]  last8;
        logic        want_v2, want_v8;
`ifdef MUX_SWITCH_CNT_EN
        int          sw = 0;
        logic        prev_s = 1'b0;
`endif
        do_reset();
        last2 = 2'b00;
        last8 = 8'h00;
        for (int i = 0; i < 300; i++) begin
            a2 = 2'($urandom);
            b2 = 2'($urandom);
            s2 = 1'($urandom);
            en2 = ($urandom_range(0, 3) != 0);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            s8 = 1'($urandom);
            en8 = ($urandom_range(0, 3) != 0);
            if (en2) last2 = s2 ? b2 : a2;
            if (en8) last8 = s8 ? b8 : a8;
            want_v2 = en2;
            want_v8 = en8;
`ifdef MUX_SWITCH_CNT_EN
            if (en2) begin
                if (s2 != prev_s && sw < 65535) sw++;
                prev_s = s2;
            end
`endif
            tick();
            n_cmp++;
            if (y2 !== last2 || v2 !== want_v2) begin
                n_bad++;
                $display("FAIL rand2[%0d] y=%b vld=%b want %b/%b",
                         i, y2, v2, last2, want_v2);
            end
            n_cmp++;
            if (y8 !== last8 || v8 !== want_v8) begin
                n_bad++;
                $display("FAIL rand8[%0d] y=%h vld=%b want %h/%b",
                         i, y8, v8, last8, want_v8);
            end
`ifdef MUX_SWITCH_CNT_EN
            n_cmp++;
            if (cnt2 !== 16'(sw) || sq2 !== prev_s) begin
                n_bad++;
                $display("FAIL rand_cnt[%0d] cnt=%0d sel_q=%b want %0d/%b",
                         i, cnt2, sq2, sw, prev_s);
            end
`endif
        end
        en2 = 1'b0;
        en8 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a2 = '0; b2 = '0; s2 = 1'b0; en2 = 1'b0;
        a8 = '0; b8 = '0; s8 = 1'b0; en8 = 1'b0;
`ifdef MUX_SWITCH_CNT_EN
        as = '0; bs = '0; ss = 1'b0; ens = 1'b0;
`endif
        test_reset();
        test_select_a();
        test_select_b();
        test_hold();
        test_equal_inputs();
        test_width_sweep();
`ifdef MUX_SWITCH_CNT_EN
        test_switch_cnt();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
